// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog timer core.
// Holds the FIFO command entry layout, the FSM state encoding and the
// small decode helpers that turn an entry into kick/enable actions.
package wdt_pkg;

    // Width of one command entry popped from the async FIFO
    localparam int WDT_CMD_W = 37;

    // Width of the timeout field carried inside an entry
    localparam int WDT_TO_W = 32;

    // Bit positions of the individual fields inside an entry
    localparam int WDT_BIT_WDEN_VALID   = 36;
    localparam int WDT_BIT_WDEN         = 35;
    localparam int WDT_BIT_WDLIVE_VALID = 34;
    localparam int WDT_BIT_WDLIVE       = 33;
    localparam int WDT_BIT_WTOCNT_VALID = 32;
    localparam int WDT_BIT_WTOCNT_MSB   = 31;
    localparam int WDT_BIT_WTOCNT_LSB   = 0;

    // One FIFO entry; declaration order gives the bit layout above
    typedef struct packed {
        logic                wden_valid;
        logic                wden;
        logic                wdlive_valid;
        logic                wdlive;
        logic                wtocnt_valid;
        logic [WDT_TO_W-1:0] wtocnt;
    } wdt_cmd_t;

    // Watchdog FSM states; 2'b11 is unused and recovers to DISABLED
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        EXPIRED  = 2'd2
    } wdt_state_e;

    // Kick request carried by an entry
    function automatic logic cmd_kick(input wdt_cmd_t cmd);
        return cmd.wdlive_valid & cmd.wdlive;
    endfunction

    // Enable request carried by an entry
    function automatic logic cmd_en_set(input wdt_cmd_t cmd);
        return cmd.wden_valid & cmd.wden;
    endfunction

    // Disable request carried by an entry
    function automatic logic cmd_en_clr(input wdt_cmd_t cmd);
        return cmd.wden_valid & ~cmd.wden;
    endfunction

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running prescaler for the watchdog counter.
// Counts while the watchdog is in RUN and flags a tick on the all-ones
// value. Only built when WDT_PRESCALE_EN is defined; without it the core
// advances its counter every RUN cycle and this module does not exist.
`ifdef WDT_PRESCALE_EN
module wdt_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ONES = {PRESC_W{1'b1}};

    logic [PRESC_W-1:0] r_presc;

    // Prescale counter: cleared outside RUN or on request, otherwise wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clr || !run) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    assign tick = run & (r_presc == PRESC_ONES);

endmodule
`endif

// File: rtl/wdt_core.sv
// Watchdog timer core, timer clock domain.
// Consumes one command entry per cycle from a show-ahead FIFO, updates the
// timeout register, and runs a DISABLED/RUN/EXPIRED FSM around a
// non-wrapping up-counter. wto_interrupt is a registered level that is high
// exactly while the FSM sits in EXPIRED.
// Optional build macro: WDT_PRESCALE_EN slows the counter by 2^PRESC_W.
module wdt_core
    import wdt_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WDT_CMD_W-1:0] fifo_rdata,
    input  logic                 fifo_rempty,
    output logic                 fifo_rpop,
    output logic                 wto_interrupt,
    output logic [1:0]           wdt_state,
    output logic [CNT_W-1:0]     wdt_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    wdt_cmd_t          w_cmd;
    logic              w_pop;
    logic              w_kick;
    logic              w_en_set;
    logic              w_en_clr;
    logic              w_tick;

    wdt_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_wtocnt;
    logic              r_wto;

    // Every non-empty head is accepted; nothing is consumed while in reset
    assign w_pop     = ~fifo_rempty & ~rst;
    assign fifo_rpop = w_pop;

    assign w_cmd    = wdt_cmd_t'(fifo_rdata);
    assign w_kick   = w_pop & cmd_kick(w_cmd);
    assign w_en_set = w_pop & cmd_en_set(w_cmd);
    assign w_en_clr = w_pop & cmd_en_clr(w_cmd);

`ifdef WDT_PRESCALE_EN
    logic w_run;
    logic w_presc_clr;

    assign w_run       = (r_state == RUN);
    assign w_presc_clr = w_kick | w_en_clr;

    wdt_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_presc_clr),
        .run  (w_run),
        .tick (w_tick)
    );
`else
    // Without a prescaler every RUN cycle is a counting cycle; the condition
    // below is always true and only keeps PRESC_W referenced in this build.
    assign w_tick = (PRESC_W >= 0) || (PRESC_W < 0);
`endif

    // Timeout register: loaded from any entry carrying a valid timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wtocnt <= CNT_ZERO;
        end else if (w_pop && w_cmd.wtocnt_valid) begin
            r_wtocnt <= w_cmd.wtocnt[CNT_W-1:0];
        end else begin
            r_wtocnt <= r_wtocnt;
        end
    end

    // Watchdog FSM with counter and registered interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DISABLED;
            r_cnt   <= CNT_ZERO;
            r_wto   <= 1'b0;
        end else begin
            case (r_state)
                DISABLED: begin
                    r_cnt <= CNT_ZERO;
                    r_wto <= 1'b0;
                    if (w_en_set) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= DISABLED;
                    end
                end
                RUN: begin
                    if (w_en_clr) begin
                        r_state <= DISABLED;
                        r_cnt   <= CNT_ZERO;
                        r_wto   <= 1'b0;
                    end else if (w_kick) begin
                        r_state <= RUN;
                        r_cnt   <= CNT_ZERO;
                        r_wto   <= 1'b0;
                    end else if (w_tick) begin
                        // Compare uses the timeout held before this edge;
                        // >= lets a lowered timeout expire immediately.
                        if (r_cnt >= r_wtocnt) begin
                            r_state <= EXPIRED;
                            r_cnt   <= r_cnt;
                            r_wto   <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_cnt   <= r_cnt + CNT_ONE;
                            r_wto   <= 1'b0;
                        end
                    end else begin
                        r_state <= RUN;
                        r_cnt   <= r_cnt;
                        r_wto   <= 1'b0;
                    end
                end
                EXPIRED: begin
                    if (w_en_clr) begin
                        r_state <= DISABLED;
                        r_cnt   <= CNT_ZERO;
                        r_wto   <= 1'b0;
                    end else if (w_kick) begin
                        r_state <= RUN;
                        r_cnt   <= CNT_ZERO;
                        r_wto   <= 1'b0;
                    end else begin
                        r_state <= EXPIRED;
                        r_cnt   <= r_cnt;
                        r_wto   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DISABLED;
                    r_cnt   <= CNT_ZERO;
                    r_wto   <= 1'b0;
                end
            endcase
        end
    end

    assign wto_interrupt = r_wto;
    assign wdt_state     = r_state;
    assign wdt_count     = r_cnt;

endmodule

// File: tb/tb_wdt_core.sv
// Scoreboard bench for wdt_core: directed scenarios plus random traffic,
// checked against a behavioural watchdog model.
module tb_wdt_core;

    localparam int PRESC_W = 2;
`ifdef WDT_PRESCALE_EN
    localparam int P = 1 << PRESC_W;
`else
    localparam int P = 1;
`endif

    logic        clk;
    logic        rst;
    logic [36:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rpop;
    logic        wto_interrupt;
    logic [1:0]  wdt_state;
    logic [31:0] wdt_count;

    wdt_core #(.CNT_W(32), .PRESC_W(PRESC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_rdata    (fifo_rdata),
        .fifo_rempty   (fifo_rempty),
        .fifo_rpop     (fifo_rpop),
        .wto_interrupt (wto_interrupt),
        .wdt_state     (wdt_state),
        .wdt_count     (wdt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        intr;
        logic        pop;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: mode 0=off, 1=running, 2=timed out
    int          m_mode;
    longint      m_cnt;
    longint      m_to;
    int          m_phase;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [36:0] mk(input bit ev, input bit e, input bit lv, input bit l,
                                       input bit tv, input logic [31:0] t);
        return {ev, e, lv, l, tv, t};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_to = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit empty, input logic [36:0] d);
        bit go_on, go_off, kick;
        go_on  = !empty && d[36] && d[35];
        go_off = !empty && d[36] && !d[35];
        kick   = !empty && d[34] && d[33];
        if (m_mode == 0) begin
            if (go_on) begin m_mode = 1; m_phase = 0; end
            m_cnt = 0;
        end else if (go_off) begin
            m_mode = 0; m_cnt = 0; m_phase = 0;
        end else if (kick) begin
            m_mode = 1; m_cnt = 0; m_phase = 0;
        end else if (m_mode == 1) begin
            if (m_phase == P - 1) begin
                if (m_cnt >= m_to) m_mode = 2;
                else m_cnt = m_cnt + 1;
            end
            m_phase = (m_mode == 1) ? (m_phase + 1) % P : 0;
        end
        if (!empty && d[32]) m_to = longint'(d[31:0]);
    endtask

    // Present one FIFO head for one cycle and queue the expected response
    task automatic drive(input bit empty, input logic [36:0] d);
        exp_t e;
        @(negedge clk);
        fifo_rempty = empty;
        fifo_rdata  = d;
        model_step(empty, d);
        e.st   = m_mode[1:0];
        e.cnt  = m_cnt[31:0];
        e.intr = (m_mode == 2);
        e.pop  = !empty;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 37'h0);
    endtask

    task automatic drain();
        int budget;
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: compare outputs just after each edge against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                chk("state", wdt_state, e.st);
                chk("count", wdt_count, e.cnt);
                chk("intr",  wto_interrupt, e.intr);
                chk("rpop",  fifo_rpop, e.pop);
            end
        end
    end

    initial begin
        rst = 1'b1; fifo_rempty = 1'b1; fifo_rdata = 37'h0;
        model_reset();
        #23;
        chk("rst_state", wdt_state, 0);
        chk("rst_count", wdt_count, 0);
        chk("rst_intr",  wto_interrupt, 0);
        chk("rst_rpop",  fifo_rpop, 0);
        @(negedge clk); rst = 1'b0;

        // Idle FIFO keeps the block disabled
        idle(10);

        // Timeout 5: counts 0..5 then expires and holds
        drive(1'b0, mk(0, 0, 0, 0, 1, 32'd5));
        drive(1'b0, mk(1, 1, 0, 0, 0, 32'd0));
        idle(6 * P + 8);

        // Kick out of EXPIRED, then disable and stay disabled
        drive(1'b0, mk(0, 0, 1, 1, 0, 32'd0));
        idle(2);
        drive(1'b0, mk(1, 0, 0, 0, 0, 32'd0));
        idle(8);

        // Combined disable+kick+timeout while running at count 2
        drive(1'b0, mk(0, 0, 0, 0, 1, 32'd10));
        drive(1'b0, mk(1, 1, 0, 0, 0, 32'd0));
        while (m_cnt < 2) drive(1'b1, 37'h0);
        drive(1'b0, mk(1, 0, 1, 1, 1, 32'd3));
        idle(4);

        // Periodic kicks at count 7 with timeout 10 keep it alive
        drive(1'b0, mk(0, 0, 0, 0, 1, 32'd10));
        drive(1'b0, mk(1, 1, 0, 0, 0, 32'd0));
        for (int i = 0; i < 100 * P; i++) begin
            if (m_cnt == 7) drive(1'b0, mk(0, 0, 1, 1, 0, 32'd0));
            else            drive(1'b1, 37'h0);
        end

        // Lower the timeout below the running count
        drive(1'b0, mk(0, 0, 0, 0, 1, 32'd2));
        idle(2 * P + 2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            if ($urandom_range(0, 99) < 40) begin
                drive(1'b1, {$urandom_range(0, 31), $urandom()});
            end else begin
                t = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
                drive(1'b0, mk($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                               $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
                               $urandom_range(0, 9) < 2, t));
            end
        end

        // Asynchronous reset in the middle of a count
        drive(1'b0, mk(0, 0, 0, 0, 1, 32'd20));
        drive(1'b0, mk(1, 1, 0, 0, 0, 32'd0));
        idle(5 * P);
        drain();
        chk("pre_rst_count_nonzero", (wdt_count != 0), 1);
        #3;
        rst = 1'b1;
        fifo_rempty = 1'b1;
        #1;
        chk("midrst_count", wdt_count, 0);
        chk("midrst_intr",  wto_interrupt, 0);
        chk("midrst_state", wdt_state, 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
